// File: rtl/trim_pkg.sv
// trim_pkg: shared types and defaults for the bandgap trim SAR controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trim_pkg;

  localparam int DEF_CODE_W      = 12;
  localparam int DEF_SETTLE_CYC  = 50000;
  localparam int DEF_LOAD_TO_CYC = 2000000;

  // Width of a counter that must reach the larger of two cycle limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SETTLE_CYC, DEF_LOAD_TO_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_BIT,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_APPLY,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/trim_sar_ctrl_if.sv
// trim_sar_ctrl_if: start/abort, comparator, loader handshake and result bundle.
// Latency: n/a (wiring only).
// Backpressure: loader stalls the controller by withholding LOAD_ACK.
interface trim_sar_ctrl_if
  import trim_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
);
  logic              START;
  logic              ABORT;
  logic              CMP;
  logic              LOAD_REQ;
  logic [CODE_W-1:0] LOAD_CODE;
  logic              LOAD_ACK;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [CODE_W-1:0] TRIM_RESULT;

  modport master (
    input  START, ABORT, CMP, LOAD_ACK,
    output LOAD_REQ, LOAD_CODE, BUSY, DONE, ERR, TRIM_RESULT
  );

  modport slave (
    output START, ABORT, CMP, LOAD_ACK,
    input  LOAD_REQ, LOAD_CODE, BUSY, DONE, ERR, TRIM_RESULT
  );
endinterface

// File: rtl/trim_sync2.sv
// trim_sync2: two-flop synchronizer for a slow asynchronous status line.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none.
module trim_sync2
  import trim_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops to let a metastable first stage resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/trim_sar_ctrl.sv
// trim_sar_ctrl: MSB-first successive-approximation trim search; optional TRIM_MAJORITY_EN votes 2-of-3 comparator samples.
// Latency: START->DONE = 1 + CODE_W*(1 + handshake + SETTLE_CYC + 1 [+2*gap]) + handshake + 1 cycles.
// Backpressure: every trial code waits for LOAD_ACK; LOAD_TO_CYC cycles without it sets sticky ERR and returns to IDLE.
module trim_sar_ctrl
  import trim_pkg::*;
#(
  parameter int CODE_W      = DEF_CODE_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int LOAD_TO_CYC = DEF_LOAD_TO_CYC
) (
  input logic             CLK50,
  input logic             RST_N,
  trim_sar_ctrl_if.master bus
);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int CW    = cnt_width(SETTLE_CYC, LOAD_TO_CYC);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] result;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              load_req;
  logic              busy;
  logic              done;
  logic              err;
  logic              cmp_s;
  logic              cmp_vote;
  logic              sample_last;

  trim_sync2 u_cmp_sync (
    .clk   (CLK50),
    .rst_n (RST_N),
    .d     (bus.CMP),
    .q     (cmp_s)
  );

  // Counter holds at all-ones instead of wrapping.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef TRIM_MAJORITY_EN
  localparam int GAP = (SETTLE_CYC / 4 > 0) ? SETTLE_CYC / 4 : 1;
  // smp[1] = first sample (end of settle), smp[0] = second; cmp_s is the third.
  logic [1:0] smp;
  assign sample_last = (cnt == CW'(2 * GAP));
  assign cmp_vote    = (smp[1] & smp[0]) | (smp[1] & cmp_s) | (smp[0] & cmp_s);
`else
  assign sample_last = 1'b1;
  assign cmp_vote    = cmp_s;
`endif

  // Search sequencer: all outputs are registered here; ABORT overrides everything but reset.
  always_ff @(posedge CLK50) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      idx      <= IDX_W'(CODE_W - 1);
      code     <= '0;
      result   <= '0;
      cnt      <= '0;
      load_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef TRIM_MAJORITY_EN
      smp      <= '0;
`endif
    end else if (bus.ABORT) begin
      state    <= ST_IDLE;
      load_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A START landing on the DONE cycle belongs to the finished search.
          if (bus.START && !done) begin
            code  <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            idx   <= IDX_W'(CODE_W - 1);
            state <= ST_SET_BIT;
          end
        end
        ST_SET_BIT: begin
          code[idx] <= 1'b1;
          load_req  <= 1'b1;
          cnt       <= '0;
          state     <= ST_LOAD;
        end
        ST_LOAD, ST_APPLY: begin
          if (bus.LOAD_ACK) begin
            load_req <= 1'b0;
            cnt      <= '0;
            state    <= (state == ST_LOAD) ? ST_SETTLE : ST_FINISH;
          end else if (cnt >= CW'(LOAD_TO_CYC - 1)) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            load_req <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_SETTLE: begin
          if (cnt >= CW'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_SAMPLE: begin
          if (sample_last) begin
            if (cmp_vote) code[idx] <= 1'b0;
            cnt <= '0;
            if (idx == '0) begin
              // Final code goes straight out; the cleared bit is visible with LOAD_REQ.
              load_req <= 1'b1;
              state    <= ST_APPLY;
            end else begin
              idx   <= idx - 1'b1;
              state <= ST_SET_BIT;
            end
          end else begin
`ifdef TRIM_MAJORITY_EN
            if (cnt == '0 || cnt == CW'(GAP)) smp <= {smp[0], cmp_s};
`endif
            cnt <= cnt_inc;
          end
        end
        ST_FINISH: begin
          result <= code;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.LOAD_REQ    = load_req;
  assign bus.LOAD_CODE   = code;
  assign bus.BUSY        = busy;
  assign bus.DONE        = done;
  assign bus.ERR         = err;
  assign bus.TRIM_RESULT = result;
endmodule

// File: tb/tb_trim_sar_ctrl.sv
// tb_trim_sar_ctrl: directed bench for trim_sar_ctrl with loader and comparator models.
// Latency: loader acks 13 cycles after LOAD_REQ rises; comparator follows the last acked code.
// Backpressure: loader can be disabled to provoke the load timeout.
module tb_trim_sar_ctrl;
  localparam int CW      = 12;
  localparam int SETTLE  = 4;
  localparam int LOAD_TO = 64;
  localparam int ACK_DLY = 13;
  localparam int THR     = 'h5A3;
`ifdef TRIM_MAJORITY_EN
  localparam int GAP   = (SETTLE / 4 > 0) ? SETTLE / 4 : 1;
  localparam int EXTRA = 2 * GAP;
`else
  localparam int EXTRA = 0;
`endif
  // Spec latency: START register + CODE_W bits + one extra load + FINISH.
  localparam int EXP_LAT = 1 + CW * (1 + ACK_DLY + SETTLE + EXTRA + 1) + ACK_DLY + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trim_sar_ctrl_if #(.CODE_W(CW)) bus ();

  trim_sar_ctrl #(
    .CODE_W      (CW),
    .SETTLE_CYC  (SETTLE),
    .LOAD_TO_CYC (LOAD_TO)
  ) dut (
    .CLK50 (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Comparator law: 0 = code above THR, 1 = tied high, 2 = tied low.
  function automatic bit cmp_of(input int mode, input int code);
    case (mode)
      0:       return code > THR;
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] load_log[$];
  logic [CW-1:0] exp_final    = '0;
  logic [CW-1:0] model_result = '0;

  // Trial codes of an ideal binary search, plus the result as the largest code with CMP=0.
  task automatic build_model(input int mode, output logic [CW-1:0] fin);
    int acc;
    acc = 0;
    exp_q.delete();
    for (int b = CW - 1; b >= 0; b--) begin
      int t;
      t = acc | (1 << b);
      exp_q.push_back(CW'(t));
      if (!cmp_of(mode, t)) acc = t;
    end
    fin = '0;
    for (int c = 0; c < (1 << CW); c++) if (!cmp_of(mode, c)) fin = CW'(c);
    exp_q.push_back(fin);
  endtask

  // Loader + comparator model.
  int            cmp_mode    = 0;
  bit            loader_en   = 1'b1;
  int            req_age     = 0;
  logic [CW-1:0] applied     = '0;
  int            glitch_cnt  = 0;
  bit            glitch_arm  = 1'b0;
  logic [CW-1:0] glitch_code = '0;

  initial begin
    bus.LOAD_ACK = 1'b0;
    bus.CMP      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.LOAD_ACK = 1'b0;
      if (bus.LOAD_REQ) req_age++;
      else req_age = 0;
      if (loader_en && bus.LOAD_REQ && req_age == ACK_DLY) begin
        bus.LOAD_ACK = 1'b1;
        applied      = bus.LOAD_CODE;
        if (glitch_arm && applied == glitch_code) begin
          glitch_cnt = 5;
          glitch_arm = 1'b0;
        end
      end
      if (glitch_cnt > 0) glitch_cnt--;
      bus.CMP = cmp_of(cmp_mode, int'(applied)) | (glitch_cnt == 1);
    end
  end

  // Per-cycle compare against the model.
  bit            prev_req = 1'b0;
  bit            rst_prev = 1'b0;
  logic [CW-1:0] held_code = '0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst_prev) begin
      model_result = '0;
      prev_req     = 1'b0;
    end
    if (bus.LOAD_REQ && !prev_req) begin
      load_log.push_back(bus.LOAD_CODE);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load actual=0x%0h expected=no_load", bus.LOAD_CODE);
      end else begin
        check("load_code", bus.LOAD_CODE, exp_q.pop_front());
      end
      held_code = bus.LOAD_CODE;
    end else if (bus.LOAD_REQ) begin
      check("load_code_stable", bus.LOAD_CODE, held_code);
    end
    if (bus.DONE) begin
      done_cnt++;
      model_result = exp_final;
      check("busy_low_at_done", bus.BUSY, 0);
    end
    check("trim_result", bus.TRIM_RESULT, model_result);
    prev_req = bus.LOAD_REQ;
    rst_prev = !rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full search; l1/l2 are the hand-derived 2nd and 3rd trial codes.
  task automatic run_search(input int mode, input logic [CW-1:0] exp_res,
                            input logic [CW-1:0] l1, input logic [CW-1:0] l2, input bit sod);
    logic [CW-1:0] fin;
    int cyc;
    int busy_drop;
    bit seen;
    build_model(mode, fin);
    exp_final = fin;
    cmp_mode  = mode;
    load_log.delete();
    tick();
    bus.START = 1'b1;
    cyc = 0;
    busy_drop = 0;
    seen = 1'b0;
    while (cyc < 5000 && !seen) begin
      @(posedge clk);
      cyc++;
      #1;
      bus.START = 1'b0;
      @(negedge clk);
      if (bus.DONE) seen = 1'b1;
      else if (!bus.BUSY) busy_drop++;
    end
    check("done_seen", seen, 1);
    check("latency", cyc, EXP_LAT);
    check("busy_held", busy_drop, 0);
    check("result_literal", bus.TRIM_RESULT, exp_res);
    check("load_count", load_log.size(), CW + 1);
    check("load0", load_log[0], 12'h800);
    check("load1", load_log[1], l1);
    check("load2", load_log[2], l2);
    check("load_final", load_log[CW], exp_res);
    if (sod) bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    @(negedge clk);
    check("done_one_cycle", bus.DONE, 0);
    check("no_restart_after_done", bus.BUSY, 0);
  endtask

  initial begin
    int cyc;
    int req_cyc;
    int got;
    int done0;
    rst_n = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_load_req", bus.LOAD_REQ, 0);
    check("rst_load_code", bus.LOAD_CODE, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_result", bus.TRIM_RESULT, 0);
    tick();
    rst_n = 1'b1;

    // Basic search, with a START on the DONE cycle that must be ignored.
    run_search(0, 12'h5A3, 12'h400, 12'h600, 1'b1);
    // Extremes.
    run_search(1, 12'h000, 12'h400, 12'h200, 1'b0);
    run_search(2, 12'hFFF, 12'hC00, 12'hE00, 1'b0);

    // Load timeout: loader silent.
    loader_en = 1'b0;
    exp_q.delete();
    exp_q.push_back(12'h800);
    done0 = done_cnt;
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    cyc = 0;
    req_cyc = 0;
    while (cyc < 300 && !bus.ERR) begin
      @(negedge clk);
      cyc++;
      if (bus.LOAD_REQ) req_cyc++;
    end
    check("to_err", bus.ERR, 1);
    check("to_req_cycles", req_cyc, LOAD_TO);
    check("to_load_req", bus.LOAD_REQ, 0);
    check("to_busy", bus.BUSY, 0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", bus.ERR, 1);
    check("to_no_done", done_cnt - done0, 0);
    check("to_result_kept", bus.TRIM_RESULT, 12'hFFF);
    loader_en = 1'b1;

    // ABORT in SETTLE of bit 7 (5th trial, 0x580).
    begin
      logic [CW-1:0] fin;
      build_model(0, fin);
      exp_final = fin;
    end
    cmp_mode = 0;
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    @(negedge clk);
    check("err_cleared_by_start", bus.ERR, 0);
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.LOAD_ACK) got++;
    end
    check("abort_reached_bit7", got, 5);
    done0 = done_cnt;
    tick();
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.BUSY, 0);
    check("abort_load_req", bus.LOAD_REQ, 0);
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - done0, 0);
    check("abort_stays_idle", bus.BUSY, 0);
    run_search(0, 12'h5A3, 12'h400, 12'h600, 1'b0);

    // START re-pulsed while busy, then reset during the 4th LOAD.
    begin
      logic [CW-1:0] fin;
      build_model(0, fin);
      exp_final = fin;
    end
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.LOAD_ACK) got++;
    end
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    while (got < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.LOAD_ACK) got++;
    end
    while (!bus.LOAD_REQ && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_through_restart", bus.BUSY, 1);
    check("in_fourth_load", bus.LOAD_REQ, 1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_load_req", bus.LOAD_REQ, 0);
    check("mid_rst_load_code", bus.LOAD_CODE, 0);
    check("mid_rst_busy", bus.BUSY, 0);
    check("mid_rst_done", bus.DONE, 0);
    check("mid_rst_err", bus.ERR, 0);
    check("mid_rst_result", bus.TRIM_RESULT, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    run_search(0, 12'h5A3, 12'h400, 12'h600, 1'b0);

`ifdef TRIM_MAJORITY_EN
    // Bit 11 already reads 1 at 0x800, so the one-sample high glitch goes on bit 10 (0x400, true CMP=0).
    glitch_code = 12'h400;
    glitch_arm  = 1'b1;
    run_search(0, 12'h5A3, 12'h400, 12'h600, 1'b0);
    check("glitch_fired", glitch_arm, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
